// File: rtl/checkout_ctrl.sv
// Checkout sequencer: feeds item operands to unit_price, accumulates the running total,
// then collects coins and returns change, or refunds the paid amount on cancel.
module checkout_ctrl #(
    parameter int TOTAL_W   = 10,
    parameter int MAX_ITEMS = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_item_valid,
    output logic               o_item_ready,
    input  logic [3:0]         i_item_price,
    input  logic [3:0]         i_item_num,
    input  logic               i_checkout,
    input  logic               i_coin_valid,
    input  logic [3:0]         i_coin_value,
    input  logic               i_cancel,
    output logic [3:0]         o_up_price,
    output logic [3:0]         o_up_num,
    input  logic [7:0]         i_up_product,
    output logic [TOTAL_W-1:0] o_total,
    output logic [TOTAL_W-1:0] o_paid,
    output logic [TOTAL_W-1:0] o_change,
    output logic [3:0]         o_item_count,
    output logic               o_done,
    output logic               o_refund,
    output logic               o_ovf
);

    localparam int SUM_W = TOTAL_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACC,
        S_PAY,
        S_DONE
    } state_t;

    state_t             r_state, w_next_state;
    logic [3:0]         r_up_price, w_next_up_price;
    logic [3:0]         r_up_num, w_next_up_num;
    logic [TOTAL_W-1:0] r_total, w_next_total;
    logic [TOTAL_W-1:0] r_paid, w_next_paid;
    logic [TOTAL_W-1:0] r_change, w_next_change;
    logic [3:0]         r_item_count, w_next_item_count;
    logic               r_item_ready, w_next_item_ready;
    logic               r_done, w_next_done;
    logic               r_refund, w_next_refund;
    logic               r_ovf, w_next_ovf;

    logic [SUM_W-1:0]   w_total_sum;
    logic [SUM_W-1:0]   w_paid_sum;
    logic               w_cancel_hit;
    logic               w_accept;

    // The extra top bit of each sum is the saturation flag.
    assign w_total_sum  = SUM_W'(r_total) + SUM_W'(i_up_product);
    assign w_paid_sum   = SUM_W'(r_paid) + SUM_W'(i_coin_value);
    assign w_cancel_hit = i_cancel &&
                          ((r_state inside {S_ISSUE, S_ACC, S_PAY}) ||
                           (r_state == S_IDLE && r_item_count != 4'd0));
    assign w_accept     = (r_state == S_IDLE) && i_item_valid && r_item_ready && !i_cancel;

    always_comb begin
        w_next_state      = r_state;
        w_next_up_price   = r_up_price;
        w_next_up_num     = r_up_num;
        w_next_total      = r_total;
        w_next_paid       = r_paid;
        w_next_change     = r_change;
        w_next_item_count = r_item_count;
        w_next_done       = 1'b0;
        w_next_refund     = 1'b0;
        w_next_ovf        = r_ovf;

        if (w_cancel_hit) begin
            w_next_change     = r_paid;
            w_next_refund     = 1'b1;
            w_next_total      = '0;
            w_next_paid       = '0;
            w_next_item_count = 4'd0;
            w_next_ovf        = 1'b0;
            w_next_state      = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_next_up_price = i_item_price;
                        w_next_up_num   = i_item_num;
                        w_next_change   = '0;
                        w_next_state    = S_ISSUE;
                    end else if (i_checkout && r_item_count != 4'd0) begin
                        w_next_state = S_PAY;
                    end
                end
                S_ISSUE: w_next_state = S_ACC;
                S_ACC: begin
                    w_next_total      = w_total_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : w_total_sum[TOTAL_W-1:0];
                    w_next_ovf        = r_ovf | w_total_sum[TOTAL_W];
                    w_next_item_count = r_item_count + 4'd1;
                    w_next_state      = S_IDLE;
                end
                S_PAY: begin
                    // The compare uses the registered paid value; a coin arriving now still counts.
                    if (i_coin_valid) begin
                        w_next_paid = w_paid_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : w_paid_sum[TOTAL_W-1:0];
                        w_next_ovf  = r_ovf | w_paid_sum[TOTAL_W];
                    end
                    if (r_paid >= r_total) begin
                        w_next_state = S_DONE;
                    end
                end
                S_DONE: begin
                    w_next_change     = r_paid - r_total;
                    w_next_done       = 1'b1;
                    w_next_total      = '0;
                    w_next_paid       = '0;
                    w_next_item_count = 4'd0;
                    w_next_ovf        = 1'b0;
                    w_next_state      = S_IDLE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end

        w_next_item_ready = (w_next_state == S_IDLE) && (w_next_item_count < 4'(MAX_ITEMS));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_up_price   <= 4'd0;
            r_up_num     <= 4'd0;
            r_total      <= '0;
            r_paid       <= '0;
            r_change     <= '0;
            r_item_count <= 4'd0;
            r_item_ready <= 1'b0;
            r_done       <= 1'b0;
            r_refund     <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_up_price   <= w_next_up_price;
            r_up_num     <= w_next_up_num;
            r_total      <= w_next_total;
            r_paid       <= w_next_paid;
            r_change     <= w_next_change;
            r_item_count <= w_next_item_count;
            r_item_ready <= w_next_item_ready;
            r_done       <= w_next_done;
            r_refund     <= w_next_refund;
            r_ovf        <= w_next_ovf;
        end
    end

    assign o_item_ready = r_item_ready;
    assign o_up_price   = r_up_price;
    assign o_up_num     = r_up_num;
    assign o_total      = r_total;
    assign o_paid       = r_paid;
    assign o_change     = r_change;
    assign o_item_count = r_item_count;
    assign o_done       = r_done;
    assign o_refund     = r_refund;
    assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_checkout_ctrl.sv
// Directed bench for checkout_ctrl with an 8-bit total and two-item limit; a small unit_price
// model closes the loop and a queue of expected output snapshots is popped after each edge.
module tb_checkout_ctrl;

    localparam int TW   = 8;
    localparam int MAXI = 2;

    logic          clk = 1'b0;
    logic          rstN;
    logic          itemValid, itemReady;
    logic [3:0]    itemPrice, itemNum;
    logic          checkoutIn, coinValid, cancelIn;
    logic [3:0]    coinValue;
    logic [3:0]    upPrice, upNum;
    logic [7:0]    upProduct = 8'd0;
    logic [TW-1:0] total, paid, change;
    logic [3:0]    itemCount;
    logic          done, refund, ovf;

    typedef struct {
        string tag;
        int    total;
        int    paid;
        int    change;
        int    count;
        bit    done;
        bit    refund;
        bit    ovf;
        bit    ready;
    } exp_t;

    exp_t sbq[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   eTotal = 0, ePaid = 0, eChange = 0, eCount = 0;
    bit   eOvf = 1'b0;

    checkout_ctrl #(.TOTAL_W(TW), .MAX_ITEMS(MAXI)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_item_valid (itemValid),
        .o_item_ready (itemReady),
        .i_item_price (itemPrice),
        .i_item_num   (itemNum),
        .i_checkout   (checkoutIn),
        .i_coin_valid (coinValid),
        .i_coin_value (coinValue),
        .i_cancel     (cancelIn),
        .o_up_price   (upPrice),
        .o_up_num     (upNum),
        .i_up_product (upProduct),
        .o_total      (total),
        .o_paid       (paid),
        .o_change     (change),
        .o_item_count (itemCount),
        .o_done       (done),
        .o_refund     (refund),
        .o_ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Registered multiplier standing in for unit_price.
    always @(posedge clk) upProduct <= 8'(upPrice) * 8'(upNum);

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit iv, input logic [3:0] p, input logic [3:0] n,
                                 input bit co, input bit cv, input logic [3:0] cval, input bit ca);
        itemValid  = iv;
        itemPrice  = p;
        itemNum    = n;
        checkoutIn = co;
        coinValid  = cv;
        coinValue  = cval;
        cancelIn   = ca;
    endtask

    task automatic expectNow(input string tag, input bit d, input bit r, input bit rdy);
        sbq.push_back('{tag, eTotal, ePaid, eChange, eCount, d, r, eOvf, rdy});
    endtask

    task automatic checkOutput();
        exp_t e;
        nChecks++;
        assert (sbq.size() != 0) else begin
            nFails++;
            $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            cmp({e.tag, ".total"},      16'(total),     16'(e.total));
            cmp({e.tag, ".paid"},       16'(paid),      16'(e.paid));
            cmp({e.tag, ".change"},     16'(change),    16'(e.change));
            cmp({e.tag, ".item_count"}, 16'(itemCount), 16'(e.count));
            cmp({e.tag, ".done"},       16'(done),      16'(e.done));
            cmp({e.tag, ".refund"},     16'(refund),    16'(e.refund));
            cmp({e.tag, ".ovf"},        16'(ovf),       16'(e.ovf));
            cmp({e.tag, ".item_ready"}, 16'(itemReady), 16'(e.ready));
        end
    endtask

    task automatic cycle(input string tag, input bit d, input bit r, input bit rdy);
        expectNow(tag, d, r, rdy);
        tick();
        checkOutput();
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic addItem(input string tag, input logic [3:0] p, input logic [3:0] n,
                           input int newTotal, input bit newOvf);
        applyStimulus(1'b1, p, n, 1'b0, 1'b0, 4'd0, 1'b0);
        eChange = 0;
        cycle({tag, ".accept"}, 1'b0, 1'b0, 1'b0);
        cmp({tag, ".up_price"}, 16'(upPrice), 16'(p));
        cmp({tag, ".up_num"},   16'(upNum),   16'(n));
        idleInputs();
        cycle({tag, ".issue"}, 1'b0, 1'b0, 1'b0);
        eTotal = newTotal;
        eCount = eCount + 1;
        eOvf   = newOvf;
        cycle({tag, ".acc"}, 1'b0, 1'b0, eCount < MAXI);
    endtask

    task automatic doCheckout(input string tag);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        cycle(tag, 1'b0, 1'b0, 1'b0);
        idleInputs();
    endtask

    task automatic payCoin(input string tag, input logic [3:0] v, input int newPaid);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, v, 1'b0);
        ePaid = newPaid;
        cycle(tag, 1'b0, 1'b0, 1'b0);
        idleInputs();
    endtask

    task automatic finishPay(input string tag, input int expChange);
        idleInputs();
        cycle({tag, ".compare"}, 1'b0, 1'b0, 1'b0);
        eChange = expChange;
        eTotal  = 0;
        ePaid   = 0;
        eCount  = 0;
        eOvf    = 1'b0;
        cycle({tag, ".done"}, 1'b1, 1'b0, 1'b1);
        cycle({tag, ".after"}, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkReset(input string tag);
        eTotal  = 0;
        ePaid   = 0;
        eChange = 0;
        eCount  = 0;
        eOvf    = 1'b0;
        expectNow(tag, 1'b0, 1'b0, 1'b0);
        checkOutput();
        cmp({tag, ".up_price"}, 16'(upPrice), 16'd0);
        cmp({tag, ".up_num"},   16'(upNum),   16'd0);
    endtask

    initial begin
        rstN = 1'b1;
        idleInputs();
        #1 rstN = 1'b0;
        #2 checkReset("reset");
        @(negedge clk) rstN = 1'b1;
        cycle("reset.release", 1'b0, 1'b0, 1'b1);

        // Two items, overpay by 3.
        addItem("t1.item0", 4'd3, 4'd4, 12, 1'b0);
        addItem("t1.item1", 4'd5, 4'd2, 22, 1'b0);
        doCheckout("t1.checkout");
        payCoin("t1.coin0", 4'd10, 10);
        payCoin("t1.coin1", 4'd10, 20);
        payCoin("t1.coin2", 4'd5, 25);
        finishPay("t1", 3);

        // Exact payment gives zero change.
        addItem("t2.item", 4'd2, 4'd5, 10, 1'b0);
        doCheckout("t2.checkout");
        payCoin("t2.coin0", 4'd5, 5);
        payCoin("t2.coin1", 4'd5, 10);
        finishPay("t2", 0);

        // Total saturates at 255 and raises ovf until done.
        addItem("t3.item0", 4'd15, 4'd15, 225, 1'b0);
        addItem("t3.item1", 4'd15, 4'd15, 255, 1'b1);
        doCheckout("t3.checkout");
        for (int k = 1; k <= 17; k++) payCoin("t3.coin", 4'd15, 15 * k);
        finishPay("t3", 0);

        // Item limit reached: held item_valid is refused, checkout still works.
        addItem("t4.item0", 4'd1, 4'd1, 1, 1'b0);
        addItem("t4.item1", 4'd1, 4'd2, 3, 1'b0);
        applyStimulus(1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 4; k++) cycle("t4.hold", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd7, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0);
        cycle("t4.checkout", 1'b0, 1'b0, 1'b0);
        payCoin("t4.coin", 4'd3, 3);
        finishPay("t4", 0);

        // Cancel wins over a same-cycle coin and refunds what was paid.
        addItem("t5.item", 4'd4, 4'd2, 8, 1'b0);
        doCheckout("t5.checkout");
        payCoin("t5.coin", 4'd7, 7);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1);
        eChange = 7;
        eTotal  = 0;
        ePaid   = 0;
        eCount  = 0;
        cycle("t5.cancel", 1'b0, 1'b1, 1'b1);
        idleInputs();
        cycle("t5.after", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1);
        cycle("t5.cancel_empty", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        cycle("t5.checkout_empty", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset while an item sits in ACC.
        applyStimulus(1'b1, 4'd6, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        eChange = 0;
        cycle("t6.accept", 1'b0, 1'b0, 1'b0);
        idleInputs();
        cycle("t6.issue", 1'b0, 1'b0, 1'b0);
        #2 rstN = 1'b0;
        #1 checkReset("t6.reset_acc");
        rstN = 1'b1;
        cycle("t6.release_acc", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset during payment.
        addItem("t6.item", 4'd2, 4'd2, 4, 1'b0);
        doCheckout("t6.checkout");
        payCoin("t6.coin", 4'd1, 1);
        #2 rstN = 1'b0;
        #1 checkReset("t6.reset_pay");
        rstN = 1'b1;
        cycle("t6.release_pay", 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
